// File: rtl/serial_shift_unit.sv
// serial_shift_unit: multi-cycle RV32I shifter (SLL/SRL/SRA) for EX.
// Moves one bit position per clock under a start/busy/done handshake.
// The pipeline stalls on busy. result holds until the next accepted start.
module serial_shift_unit #(
   parameter int N   = 32,
   parameter int SHW = 5
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [1:0]     op,
   input  logic [N-1:0]   a,
   input  logic [SHW-1:0] shamt,
   output logic           busy,
   output logic           done,
   output logic [N-1:0]   result
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b11;

   state_t         state;
   state_t         state_nxt;
   logic [N-1:0]   sr;
   logic [SHW-1:0] cnt;
   logic [1:0]     op_q;
   logic           accept;

   // A new request is taken in IDLE or DONE; a start during SHIFT is dropped.
   assign accept = start && (state != SHIFT);

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values, whatever order the blocks are evaluated in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic: shift until the counter runs out, then pulse DONE.
   // NOTE: the default assignment up front keeps this purely combinational;
   // a path that leaves state_nxt unassigned would infer a latch.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept) state_nxt = SHIFT;
         SHIFT:   if (cnt == '0) state_nxt = DONE;
         DONE:    state_nxt = accept ? SHIFT : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are decoded from state only; result comes straight from sr.
   always_comb begin
      busy   = (state == SHIFT);
      done   = (state == DONE);
      result = sr;
   end

   // Datapath: capture operands at accept, then one single-bit shift per edge.
   // The SRA fill bit is re-read from sr[N-1], which still holds a[N-1].
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr   <= '0;
         cnt  <= '0;
         op_q <= 2'b00;
      end else if (accept) begin
         sr   <= a;
         cnt  <= shamt;
         op_q <= op;
      end else if (state == SHIFT && cnt != '0) begin
         unique case (op_q)
            OP_SRL:  sr <= {1'b0, sr[N-1:1]};
            OP_SRA:  sr <= {sr[N-1], sr[N-1:1]};
            default: sr <= {sr[N-2:0], 1'b0};
         endcase
         cnt <= cnt - SHW'(1);
      end
   end

endmodule
